// File: rtl/ov7670_capture.sv
// OV7670 receive path: registers the camera byte bus on PCLK, pairs bytes into RGB565
// pixels with linear frame-buffer addresses, and flags malformed frames.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              in_clk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    // state  | meaning
    // S_IDLE | not capturing; waits for capture_en during vertical blanking
    // S_ARM  | armed in blanking; next vsync fall starts a captured frame
    // S_FRAME| capturing active video until vsync rises
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_FRAME} state_t;

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);

    state_t state, state_nx;

    logic              vs_q, hr_q, vs_d, hr_d;
    logic [7:0]        d_q;
    logic              vs_rise, vs_fall;
    logic              start_go, done_go;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [YW-1:0]     y_fin;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        hi;
    logic              phase;
    logic              sticky_err;
    logic              line_end, line_err, accept;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
            d_q  <= 8'd0;
            vs_d <= 1'b0;
            hr_d <= 1'b0;
        end else begin
            vs_q <= cam_vsync;
            hr_q <= cam_href;
            d_q  <= cam_data;
            vs_d <= vs_q;
            hr_d <= hr_q;
        end
    end

    assign vs_rise = vs_q & ~vs_d;
    assign vs_fall = ~vs_q & vs_d;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_go = 1'b0;
        done_go  = 1'b0;
        case (state)
            S_IDLE:  if (capture_en && vs_q) state_nx = S_ARM;
            S_ARM: begin
                if (!capture_en) begin
                    state_nx = S_IDLE;
                end else if (vs_fall) begin
                    state_nx = S_FRAME;
                    start_go = 1'b1;
                end
            end
            S_FRAME: begin
                if (vs_rise) begin
                    state_nx = S_IDLE;
                    done_go  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A vsync rise with href still high closes the open line in the same cycle.
    assign line_end = (state == S_FRAME) && hr_d && (!hr_q || vs_rise);
    assign line_err = phase || (x != XW'(H_ACTIVE));
    assign accept   = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
    assign y_fin    = y + YW'(line_end && (x != '0));

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data    <= 16'd0;
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            hi          <= 8'd0;
            phase       <= 1'b0;
            sticky_err  <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= start_go;
            frame_done  <= done_go;
            if (start_go) begin
                x          <= '0;
                y          <= '0;
                addr       <= '0;
                hi         <= 8'd0;
                phase      <= 1'b0;
                sticky_err <= 1'b0;
            end else if (state == S_FRAME) begin
                if (line_end) begin
                    phase <= 1'b0;
                    x     <= '0;
                    // Realign to the next row base even when the line came up short.
                    if (x != '0) begin
                        y    <= y + YW'(1);
                        addr <= addr + ADDR_W'(H_ACTIVE) - ADDR_W'(x);
                    end
                    if (line_err) sticky_err <= 1'b1;
                end else if (hr_q && !vs_rise) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hi <= d_q;
                    end else if (accept) begin
                        pix_data  <= {hi, d_q};
                        pix_valid <= 1'b1;
                        pix_addr  <= addr;
                        x         <= x + XW'(1);
                        addr      <= addr + ADDR_W'(1);
                    end else begin
                        sticky_err <= 1'b1;
                    end
                end
                if (done_go)
                    frame_err <= sticky_err || (line_end && line_err) ||
                                 (y_fin != YW'(V_ACTIVE));
            end
        end
    end

    assign busy = (state == S_FRAME);

endmodule
